// File: rtl/glitch_free_clk_sel.sv
// Glitch-free clock-source selector.
// Oversamples NUM_SRC slow clock-like inputs in the i_clk domain. It drives a
// registered copy of one of them on o_clk, and switches sources with a
// break-before-make sequence.
module glitch_free_clk_sel #(
    parameter int NUM_SRC       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int SEL_W         = (NUM_SRC == 2) ? 1 : 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic [SEL_W-1:0]   i_sel,
    output logic               o_clk,
    output logic [SEL_W-1:0]   o_cur,
    output logic               o_busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GAP   = 2'd2,
        ST_ARM   = 2'd3
    } state_t;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s;
    logic               s_cur;
    logic               sel_ok;
    logic               gap_last;
    logic               to_last;

    state_t             state_q,  state_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [SEL_W-1:0]   cur_q,    cur_d;
    logic               clk_q,    clk_d;
    logic               busy_q,   busy_d;
    logic [GAP_W-1:0]   gap_q,    gap_d;
    logic [TO_W-1:0]    to_q,     to_d;

    // Synchronizer chain: each source bit crosses through SYNC_STAGES flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_src;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign s_cur    = s[cur_q];
    // Out-of-range requests only exist when SEL_W can encode more than NUM_SRC.
    assign sel_ok   = (int'(i_sel) < NUM_SRC);
    assign gap_last = (gap_q == GAP_W'(GAP_CYCLES - 1));
    assign to_last  = (to_q == TO_W'(DRAIN_TIMEOUT - 1));

    // State, selection and output registers; reset parks in ARM on source 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_ARM;
            target_q <= '0;
            cur_q    <= '0;
            clk_q    <= 1'b0;
            busy_q   <= 1'b1;
            gap_q    <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_q    <= cur_d;
            clk_q    <= clk_d;
            busy_q   <= busy_d;
            gap_q    <= gap_d;
            to_q     <= to_d;
        end
    end

    // Switch sequencer. DRAIN lets the old high phase finish, GAP holds low,
    // and ARM waits for the new source to be low so that its first high is whole.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        clk_d    = 1'b0;
        busy_d   = busy_q;
        gap_d    = gap_q;
        to_d     = to_q;
        case (state_q)
            ST_RUN: begin
                clk_d = s_cur;
                if (sel_ok && (i_sel != cur_q)) begin
                    target_d = i_sel;
                    busy_d   = 1'b1;
                    to_d     = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A stuck-high source is cut after the timeout; that is the
                // only path that can truncate a high pulse.
                if (!s_cur || to_last) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    clk_d = 1'b1;
                    to_d  = to_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    cur_d   = target_q;
                    to_d    = '0;
                    state_d = ST_ARM;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_ARM: begin
                if (!s_cur || to_last) begin
                    busy_d  = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    assign o_clk  = clk_q;
    assign o_cur  = cur_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_glitch_free_clk_sel.sv
// Testbench for glitch_free_clk_sel. The reference model treats o_clk as the
// selected source sampled SYNC i_clk edges earlier, together with pulse-width
// and idle-gap rules around every switch.
module tb_glitch_free_clk_sel;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int SYNC = 2;
    localparam int GAP  = 2;
    localparam int TMO  = 64;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       g0 = 1'b0, g1 = 1'b0, g2 = 1'b0, g3 = 1'b0;
    logic [3:0] stuck = '0;
    logic [3:0] i_src;
    logic [1:0] i_sel = '0;
    logic       i_sel2 = 1'b0;
    logic       o_clk, o_busy, o_clk2, o_busy2, o_cur2;
    logic [1:0] o_cur;

    bit         dsel = 1'b0;
    logic       m_clk, m_busy;
    logic [1:0] m_cur;

    int n_chk = 0, n_fail = 0;
    int model_cur = 0, model_cur2 = 0;
    int cyc = 0;
    logic [3:0] hist [8];
    int hp_fl [4] = '{3, 8, 4, 5};
    int hi_run = 0, lo_run = 0;
    int hi_len_q [$];
    int lo_len_q [$];

    assign i_src  = {g3, g2, g1, g0} | stuck;
    assign m_clk  = dsel ? o_clk2  : o_clk;
    assign m_busy = dsel ? o_busy2 : o_busy;
    assign m_cur  = dsel ? {1'b0, o_cur2} : o_cur;

    glitch_free_clk_sel #(.NUM_SRC(4), .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP),
                          .DRAIN_TIMEOUT(TMO)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_src(i_src), .i_sel(i_sel),
        .o_clk(o_clk), .o_cur(o_cur), .o_busy(o_busy));

    glitch_free_clk_sel #(.NUM_SRC(2), .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP),
                          .DRAIN_TIMEOUT(TMO)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_src(i_src[1:0]), .i_sel(i_sel2),
        .o_clk(o_clk2), .o_cur(o_cur2), .o_busy(o_busy2));

    always #0.5 i_clk = ~i_clk;

    // Source edges land on x.x3 ns, never on an i_clk edge (x.0 / x.5).
    initial begin #0.03; forever #3.3 g0 = ~g0; end
    initial begin #0.13; forever #8.7 g1 = ~g1; end
    initial begin #0.23; forever #4.7 g2 = ~g2; end
    initial begin #0.33; forever #5.7 g3 = ~g3; end

    // Source history as seen at each rising edge.
    always @(posedge i_clk) begin
        cyc = cyc + 1;
        hist[cyc & 7] = i_src;
    end

    // Run-length monitor of the observed output.
    always @(negedge i_clk) begin
        if (m_clk === 1'b1) begin
            if (lo_run > 0) lo_len_q.push_back(lo_run);
            lo_run = 0;
            hi_run = hi_run + 1;
        end else begin
            if (hi_run > 0) hi_len_q.push_back(hi_run);
            hi_run = 0;
            lo_run = lo_run + 1;
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 60000ns", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (m_busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
    endtask

    task automatic check_steady(input int exp, input int ncyc, input string tag);
        int   bad = 0;
        int   bcyc = 0;
        logic e, bclk, be, bbusy;
        logic [1:0] bcur;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge i_clk);
            e = hist[(cyc - SYNC) & 7][exp];
            if (m_clk !== e || m_busy !== 1'b0 || m_cur !== 2'(exp)) begin
                if (bad == 0) begin
                    bcyc = cyc; bclk = m_clk; be = e; bbusy = m_busy; bcur = m_cur;
                end
                bad++;
            end
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s steady src %0d: %0d bad cycles; first cycle %0d o_clk=%b exp %b o_busy=%b exp 0 o_cur=%0d exp %0d",
                     tag, exp, bad, bcyc, bclk, be, bbusy, bcur, exp);
        end
    endtask

    task automatic do_switch(input int nsel, input int dwell);
        int prev, hs, thr, mn, k;
        bit ok;
        prev = dsel ? model_cur2 : model_cur;
        @(negedge i_clk);
        if (dsel) i_sel2 = nsel[0];
        else      i_sel  = nsel[1:0];
        hs = hi_len_q.size();
        @(negedge i_clk);
        n_chk++;
        if (m_busy !== (nsel != prev)) begin
            n_fail++;
            $display("FAIL busy_start %0d->%0d: o_busy=%b exp %b", prev, nsel, m_busy, nsel != prev);
        end
        if (nsel != prev) begin
            wait_idle(ok);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL switch_done %0d->%0d: o_busy still %b, exp 0", prev, nsel, m_busy);
            end
            k = 0;
            while (m_clk !== 1'b1 && k < 200) begin @(negedge i_clk); k++; end
            @(negedge i_clk);
            n_chk++;
            if (lo_len_q.size() == 0 || lo_len_q[$] < GAP + 1) begin
                n_fail++;
                $display("FAIL switch_gap %0d->%0d: low run %0d, exp >= %0d", prev, nsel,
                         (lo_len_q.size() == 0) ? 0 : lo_len_q[$], GAP + 1);
            end
        end
        if (dsel) model_cur2 = nsel;
        else      model_cur  = nsel;
        check_steady(nsel, dwell, "switch");
        thr = ((hp_fl[prev] < hp_fl[nsel]) ? hp_fl[prev] : hp_fl[nsel]) - 1;
        mn = 1000;
        for (int i = hs; i < hi_len_q.size(); i++) if (hi_len_q[i] < mn) mn = hi_len_q[i];
        n_chk++;
        if (mn < thr) begin
            n_fail++;
            $display("FAIL min_high %0d->%0d: shortest high %0d, exp >= %0d", prev, nsel, mn, thr);
        end
    endtask

    task automatic test_reset();
        bit ok;
        i_rst = 1'b1;
        i_sel = 2'd0;
        repeat (3) begin
            @(negedge i_clk);
            n_chk++;
            if (o_clk !== 1'b0 || o_busy !== 1'b1 || o_cur !== 2'd0 ||
                o_clk2 !== 1'b0 || o_busy2 !== 1'b1 || o_cur2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: clk=%b busy=%b cur=%0d clk2=%b busy2=%b cur2=%0d exp 0 1 0 0 1 0",
                         o_clk, o_busy, o_cur, o_clk2, o_busy2, o_cur2);
            end
        end
        i_rst = 1'b0;
        wait_idle(ok);
        n_chk++;
        if (!ok || o_cur !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: idle=%b o_cur=%0d exp idle 1 cur 0", ok, o_cur);
        end
        model_cur = 0;
        model_cur2 = 0;
        repeat (4) @(negedge i_clk);
        check_steady(0, 200, "after_reset");
    endtask

    task automatic test_sequence();
        int seq [11] = '{2, 1, 0, 3, 2, 0, 3, 1, 2, 3, 0};
        foreach (seq[i]) do_switch(seq[i], 221 + $urandom_range(0, 30));
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(negedge i_clk);
        i_sel = 2'd2;
        @(negedge i_clk);
        n_chk++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_start: o_busy=%b exp 1", o_busy);
        end
        i_sel = 2'd1;
        wait_idle(ok);
        n_chk++;
        if (!ok || o_cur !== 2'd2) begin
            n_fail++; $display("FAIL b2b_first: idle=%b o_cur=%0d exp idle 1 cur 2", ok, o_cur);
        end
        @(negedge i_clk);
        n_chk++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart: o_busy=%b exp 1", o_busy);
        end
        wait_idle(ok);
        n_chk++;
        if (!ok || o_cur !== 2'd1) begin
            n_fail++; $display("FAIL b2b_final: idle=%b o_cur=%0d exp idle 1 cur 1", ok, o_cur);
        end
        model_cur = 1;
        check_steady(1, 150, "b2b");
    endtask

    task automatic test_stuck();
        int k;
        bit ok;
        stuck[1] = 1'b1;
        repeat (10) @(negedge i_clk);
        i_sel = 2'd3;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge i_clk);
            if (o_clk === 1'b0) begin k = i; break; end
        end
        n_chk++;
        if (k < TMO || k > TMO + 2) begin
            n_fail++; $display("FAIL stuck_force: o_clk low after %0d cycles, exp %0d..%0d", k, TMO, TMO + 2);
        end
        wait_idle(ok);
        n_chk++;
        if (!ok || o_cur !== 2'd3) begin
            n_fail++; $display("FAIL stuck_done: idle=%b o_cur=%0d exp idle 1 cur 3", ok, o_cur);
        end
        stuck[1] = 1'b0;
        model_cur = 3;
        check_steady(3, 150, "stuck");
    endtask

    task automatic test_reset_drain();
        bit ok;
        stuck[3] = 1'b1;
        repeat (10) @(negedge i_clk);
        i_sel = 2'd0;
        repeat (10) @(negedge i_clk);
        n_chk++;
        if (o_busy !== 1'b1 || o_clk !== 1'b1) begin
            n_fail++; $display("FAIL drain_hold: o_busy=%b o_clk=%b exp 1 1", o_busy, o_clk);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        n_chk++;
        if (o_clk !== 1'b0 || o_cur !== 2'd0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_drain: clk=%b cur=%0d busy=%b exp 0 0 1", o_clk, o_cur, o_busy);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        stuck[3] = 1'b0;
        wait_idle(ok);
        n_chk++;
        if (!ok || o_cur !== 2'd0) begin
            n_fail++; $display("FAIL reset_drain_done: idle=%b o_cur=%0d exp idle 1 cur 0", ok, o_cur);
        end
        model_cur = 0;
        model_cur2 = 0;
        repeat (4) @(negedge i_clk);
        check_steady(0, 150, "reset_drain");
    endtask

    task automatic test_random();
        repeat (6) do_switch($urandom_range(0, 3), 150 + $urandom_range(0, 80));
    endtask

    task automatic test_two_src();
        @(negedge i_clk);
        dsel = 1'b1;
        check_steady(model_cur2, 300, "two_src_idle");
        repeat (6) do_switch(model_cur2 ^ 1, 221 + $urandom_range(0, 30));
        do_switch(model_cur2, 100);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_back_to_back();
        test_stuck();
        test_reset_drain();
        test_random();
        test_two_src();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
